// File: rtl/io_spi_pkg.sv
// Shared constants and state type for the IO SPI link blocks.
// The IOMODE values mirror the IO module's operating-mode encoding used elsewhere in the link.
package io_spi_pkg;

    localparam int SPI_WORD_WIDTH = 8;

    localparam logic [1:0] IOMODE_MGMT  = 2'd0;
    localparam logic [1:0] IOMODE_IN    = 2'd1;
    localparam logic [1:0] IOMODE_OUT   = 2'd2;
    localparam logic [1:0] IOMODE_FAULT = 2'd3;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } rx_state_t;

endpackage

// File: rtl/io_spi_sync.sv
// Multi-flop synchronizer for one asynchronous input, with a selectable reset value.
module io_spi_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_in,
    input  logic n_reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_in or negedge n_reset) begin
        if (!n_reset) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/io_spi_rx_interface.sv
// SPI mode-0 responder: oversamples an external master on clk_in, assembles MSB-first words
// for the controller and shifts controller-supplied words out on miso.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | n_ss high; sclk edges ignored, miso tristated
//   ACTIVE | n_ss low; sample mosi on sclk rise, update miso on sclk fall
module io_spi_rx_interface
    import io_spi_pkg::*;
#(
    parameter int WIDTH       = SPI_WORD_WIDTH,
    parameter int SYNC_STAGES = 2,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clk_in,
    input  logic                   n_reset,
    input  logic                   spi_sclk,
    input  logic                   spi_n_ss,
    input  logic                   spi_mosi,
    output logic                   spi_miso,
    output logic                   spi_miso_oe,
    input  logic [WIDTH-1:0]       tx_buffer,
    output logic                   tx_load,
    output logic [WIDTH-1:0]       rx_buffer,
    output logic                   rx_valid,
    input  logic                   rx_ack,
    output logic                   frame_start,
    output logic                   frame_end,
    output logic                   overrun,
    output logic [COUNT_WIDTH-1:0] word_count
);

    localparam int              BCW      = $clog2(WIDTH);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);

    logic sclk_sync, ss_sync, mosi_sync;
    logic sclk_d, ss_d;
    logic rise_e, fall_e, ss_fall_e, ss_rise_e;

    rx_state_t state, state_next;
    logic      boundary, shift_rx, shift_tx;

    logic [BCW-1:0]   bit_cnt;
    logic [WIDTH-1:0] rx_shift, tx_shift, rx_word;

    io_spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk_in (clk_in), .n_reset (n_reset), .d (spi_sclk), .q (sclk_sync)
    );
    io_spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
        .clk_in (clk_in), .n_reset (n_reset), .d (spi_n_ss), .q (ss_sync)
    );
    io_spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk_in (clk_in), .n_reset (n_reset), .d (spi_mosi), .q (mosi_sync)
    );

    // Strobes are registered so every consumer sees a clean single-cycle pulse.
    always_ff @(posedge clk_in or negedge n_reset) begin
        if (!n_reset) begin
            sclk_d    <= 1'b0;
            ss_d      <= 1'b1;
            rise_e    <= 1'b0;
            fall_e    <= 1'b0;
            ss_fall_e <= 1'b0;
            ss_rise_e <= 1'b0;
        end else begin
            sclk_d    <= sclk_sync;
            ss_d      <= ss_sync;
            rise_e    <= sclk_sync & ~sclk_d;
            fall_e    <= ~sclk_sync & sclk_d;
            ss_fall_e <= ~ss_sync & ss_d;
            ss_rise_e <= ss_sync & ~ss_d;
        end
    end

    always_ff @(posedge clk_in or negedge n_reset) begin
        if (!n_reset) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next  = state;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        boundary    = 1'b0;
        shift_rx    = 1'b0;
        shift_tx    = 1'b0;
        tx_load     = 1'b0;
        case (state)
            IDLE: begin
                if (ss_fall_e) begin
                    state_next  = ACTIVE;
                    frame_start = 1'b1;
                end
            end
            ACTIVE: begin
                if (ss_rise_e) begin
                    state_next = IDLE;
                    frame_end  = 1'b1;
                end else begin
                    shift_rx = rise_e;
                    shift_tx = fall_e;
                    boundary = rise_e && (bit_cnt == BIT_LAST);
                end
            end
            default: state_next = IDLE;
        endcase
        tx_load = frame_start | boundary;
    end

    assign rx_word = {rx_shift[WIDTH-2:0], mosi_sync};

    always_ff @(posedge clk_in or negedge n_reset) begin
        if (!n_reset) begin
            bit_cnt     <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            rx_buffer   <= '0;
            rx_valid    <= 1'b0;
            overrun     <= 1'b0;
            word_count  <= '0;
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
        end else begin
            if (frame_start) begin
                bit_cnt     <= '0;
                word_count  <= '0;
                overrun     <= 1'b0;
                tx_shift    <= tx_buffer;
                spi_miso    <= tx_buffer[WIDTH-1];
                spi_miso_oe <= 1'b1;
            end
            // Abort drops any partial word; completed words stay visible to the consumer.
            if (frame_end) begin
                bit_cnt     <= '0;
                spi_miso    <= 1'b0;
                spi_miso_oe <= 1'b0;
            end
            if (shift_rx) begin
                rx_shift <= rx_word;
                bit_cnt  <= boundary ? '0 : bit_cnt + 1'b1;
            end
            if (boundary) begin
                tx_shift <= tx_buffer;
                if (~&word_count) word_count <= word_count + 1'b1;
            end
            if (shift_tx) begin
                if (bit_cnt == '0) begin
                    spi_miso <= tx_shift[WIDTH-1];
                end else begin
                    tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
                    spi_miso <= tx_shift[WIDTH-2];
                end
            end
            if (boundary) begin
                if (!rx_valid || rx_ack) begin
                    rx_buffer <= rx_word;
                    rx_valid  <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_ack) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_io_spi_rx_interface.sv
// Directed bench for io_spi_rx_interface: bit-banged SPI master at clk_in/8 with hand-computed expectations.
module tb_io_spi_rx_interface;

    logic       clk_in = 1'b0;
    logic       n_reset = 1'b0;
    logic       spi_sclk = 1'b0;
    logic       spi_n_ss = 1'b1;
    logic       spi_mosi = 1'b0;
    logic       rx_ack = 1'b0;
    logic [7:0] tx_buffer = 8'h00;
    logic       spi_miso, spi_miso_oe, tx_load, rx_valid, frame_start, frame_end, overrun;
    logic [7:0] rx_buffer, word_count;

    int   tests = 0;
    int   fails = 0;
    int   fs_cnt = 0, fe_cnt = 0, tl_cnt = 0, rv_rise = 0;
    logic rv_prev = 1'b0;
    bit   auto_ack = 1'b0;
    logic v3, v4;

    io_spi_rx_interface #(.WIDTH(8), .SYNC_STAGES(2), .COUNT_WIDTH(8)) dut (
        .clk_in      (clk_in),
        .n_reset     (n_reset),
        .spi_sclk    (spi_sclk),
        .spi_n_ss    (spi_n_ss),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .tx_buffer   (tx_buffer),
        .tx_load     (tx_load),
        .rx_buffer   (rx_buffer),
        .rx_valid    (rx_valid),
        .rx_ack      (rx_ack),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .overrun     (overrun),
        .word_count  (word_count)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clk_in cycle; outputs are observed on the falling edge, away from the active edge.
    task automatic tick();
        @(negedge clk_in);
        fs_cnt  += int'(frame_start);
        fe_cnt  += int'(frame_end);
        tl_cnt  += int'(tx_load);
        rv_rise += int'(rx_valid && !rv_prev);
        rv_prev  = rx_valid;
        if (auto_ack) rx_ack = rx_valid;
    endtask

    task automatic xfer(input logic [7:0] mo, input int nbits, input bit ack_last, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = mo[3'(7 - i)];
            repeat (4) tick();
            mi[3'(7 - i)] = spi_miso;
            spi_sclk = 1'b1;
            repeat (3) tick();
            v3 = rx_valid;
            if (ack_last && i == nbits - 1) rx_ack = 1'b1;
            tick();
            v4 = rx_valid;
            if (ack_last && i == nbits - 1) rx_ack = 1'b0;
            spi_sclk = 1'b0;
        end
    endtask

    task automatic start_frame();
        spi_n_ss = 1'b0;
        repeat (8) tick();
    endtask

    task automatic end_frame();
        repeat (4) tick();
        spi_n_ss = 1'b1;
        repeat (6) tick();
    endtask

    task automatic ack_pulse();
        rx_ack = 1'b1;
        tick();
        rx_ack = 1'b0;
        tick();
    endtask

    initial begin
        logic [7:0] mi;
        int         fe0;
        int         n;

        repeat (3) tick();
        check("reset_flags", {spi_miso, spi_miso_oe, rx_valid, overrun, frame_start, frame_end, tx_load}, 0);
        check("reset_rx_buffer", rx_buffer, 8'h00);
        check("reset_word_count", word_count, 8'h00);
        n_reset = 1'b1;
        repeat (4) tick();

        // sclk activity with n_ss high must be ignored
        fs_cnt = 0; tl_cnt = 0;
        xfer(8'hFF, 8, 1'b0, mi);
        repeat (4) tick();
        check("idle_rx_valid", rx_valid, 1'b0);
        check("idle_miso_oe", spi_miso_oe, 1'b0);
        check("idle_frame_start", fs_cnt, 0);
        check("idle_tx_load", tl_cnt, 0);

        // single byte: mosi 0xA5, miso 0x3C
        tx_buffer = 8'h3C;
        start_frame();
        check("f1_frame_start", fs_cnt, 1);
        check("f1_tx_load", tl_cnt, 1);
        check("f1_miso_oe", spi_miso_oe, 1'b1);
        xfer(8'hA5, 8, 1'b0, mi);
        check("f1_miso_byte", mi, 8'h3C);
        check("f1_latency_early", v3, 1'b0);
        check("f1_latency_on_time", v4, 1'b1);
        check("f1_rx_buffer", rx_buffer, 8'hA5);
        check("f1_word_count", word_count, 8'd1);
        end_frame();
        check("f1_frame_end", fe_cnt, 1);
        check("f1_frame_start_once", fs_cnt, 1);
        check("f1_miso_oe_off", spi_miso_oe, 1'b0);
        check("f1_miso_low", spi_miso, 1'b0);
        check("f1_rx_valid_kept", rx_valid, 1'b1);
        check("f1_word_count_kept", word_count, 8'd1);
        ack_pulse();
        check("f1_ack_clears", rx_valid, 1'b0);

        // three bytes, consumer acks promptly; tx words queued one byte ahead
        tx_buffer = 8'h81;
        start_frame();
        tl_cnt = 0; rv_rise = 0;
        tx_buffer = 8'h42;
        auto_ack = 1'b1;
        xfer(8'h01, 8, 1'b0, mi);
        check("f2_miso_b0", mi, 8'h81);
        tx_buffer = 8'h99;
        xfer(8'h02, 8, 1'b0, mi);
        check("f2_miso_b1", mi, 8'h42);
        xfer(8'h03, 8, 1'b0, mi);
        check("f2_miso_b2", mi, 8'h99);
        repeat (3) tick();
        auto_ack = 1'b0;
        rx_ack = 1'b0;
        check("f2_valid_rises", rv_rise, 3);
        check("f2_tx_load", tl_cnt, 3);
        check("f2_overrun", overrun, 1'b0);
        check("f2_word_count", word_count, 8'd3);
        check("f2_last_word", rx_buffer, 8'h03);
        end_frame();

        // two bytes without ack: second is dropped
        start_frame();
        xfer(8'h11, 8, 1'b0, mi);
        check("f3_first_valid", rx_valid, 1'b1);
        xfer(8'h22, 8, 1'b0, mi);
        check("f3_rx_buffer", rx_buffer, 8'h11);
        check("f3_overrun", overrun, 1'b1);
        check("f3_word_count", word_count, 8'd2);
        end_frame();
        check("f3_overrun_sticky", overrun, 1'b1);
        ack_pulse();
        start_frame();
        check("f4_overrun_cleared", overrun, 1'b0);

        // ack lands in the same cycle as the second word boundary
        xfer(8'h11, 8, 1'b0, mi);
        xfer(8'h22, 8, 1'b1, mi);
        check("f4_rx_buffer", rx_buffer, 8'h22);
        check("f4_rx_valid", rx_valid, 1'b1);
        check("f4_overrun", overrun, 1'b0);
        end_frame();
        ack_pulse();

        // abort after 5 bits, then a clean byte
        fe0 = fe_cnt;
        start_frame();
        xfer(8'hFF, 5, 1'b0, mi);
        end_frame();
        check("f5_abort_frame_end", fe_cnt, fe0 + 1);
        check("f5_abort_no_valid", rx_valid, 1'b0);
        check("f5_abort_word_count", word_count, 8'd0);
        start_frame();
        xfer(8'h5A, 8, 1'b0, mi);
        check("f6_rx_buffer", rx_buffer, 8'h5A);
        check("f6_word_count", word_count, 8'd1);
        end_frame();

        // async reset mid-byte with n_ss held low
        tx_buffer = 8'hC3;
        start_frame();
        xfer(8'hAA, 3, 1'b0, mi);
        n_reset = 1'b0;
        spi_sclk = 1'b0;
        #1;
        check("rst_mid_flags", {spi_miso, spi_miso_oe, rx_valid, overrun, frame_start, frame_end, tx_load}, 0);
        check("rst_mid_rx_buffer", rx_buffer, 8'h00);
        check("rst_mid_word_count", word_count, 8'h00);
        repeat (2) tick();
        n_reset = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!frame_start && n < 20);
        check("rst_frame_start_latency", n, 3);
        tick();
        check("rst_new_frame_oe", spi_miso_oe, 1'b1);
        check("rst_new_frame_miso", spi_miso, 1'b1);
        end_frame();
        check("rst_new_frame_end", spi_miso_oe, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
